// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: FSM state encodings, the NOP
// instruction loaded on reset, branch_sel bit positions and a small helper.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Bit positions inside branch_sel
    localparam int BR_TAKEN = 0;
    localparam int BR_JUMP  = 1;

    // Register-indirect jump targets always have bit 0 cleared
    function automatic logic [31:0] clear_lsb(input logic [31:0] addr);
        return {addr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// Combinational next-PC selection for pc_fetch_unit.
// Priority: register-indirect jump, direct jump, taken branch, sequential.
// Optional macro FETCH_MISALIGN_CHECK_EN: when defined, a selected target
// with non-zero bits [1:0] is flagged on 'misaligned'; when undefined, the
// low two bits of the target are forced to zero and 'misaligned' is 0.
module next_pc_mux
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [1:0]  branch_sel,
    input  logic        jalr,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] target;

    // Pick the candidate next PC by priority; branch_sel = 2'b11 is a jump
    always_comb begin
        target = pc_plus4;
        if (branch_sel[BR_JUMP] && jalr) begin
            target = clear_lsb(jalr_target);
        end else if (branch_sel[BR_JUMP]) begin
            target = branch_target;
        end else if (branch_sel[BR_TAKEN]) begin
            target = branch_target;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    assign next_pc    = target;
    assign misaligned = |target[1:0];
`else
    assign next_pc    = target & ~32'h0000_0003;
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: IDLE -> FETCH -> ISSUE loop issuing one instruction at a
// time to the core, with halt and misaligned-target stops into a terminal
// HALT state. Next-PC selection lives in next_pc_mux.
// Optional macro FETCH_MISALIGN_CHECK_EN enables the misaligned-target stop;
// without it the misalign flag can never set.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  branch_sel,
    input  logic        jalr,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic        halt,
    input  logic        core_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        misalign
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  next_pc;
    logic         halted_q;
    logic         misalign_q;
    logic         target_misaligned;
    logic         issue_fire;

    // Control inputs are only meaningful on the cycle the core accepts
    assign issue_fire = (state_q == ST_ISSUE) && core_ready;

    next_pc_mux u_next_pc_mux (
        .pc_plus4      (pc_plus4),
        .branch_sel    (branch_sel),
        .jalr          (jalr),
        .branch_target (branch_target),
        .jalr_target   (jalr_target),
        .next_pc       (next_pc),
        .misaligned    (target_misaligned)
    );

    // State register; reset forces IDLE immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: halt beats misalign beats the normal PC update
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (core_ready) begin
                    if (halt || target_misaligned) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from state so reset drops them at once
    always_comb begin
        imem_req    = (state_q == ST_FETCH);
        instr_valid = (state_q == ST_ISSUE);
    end

    // PC, instruction latch and sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            instr_q    <= NOP_INSTR;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if ((state_q == ST_FETCH) && imem_ack) begin
                instr_q <= imem_rdata;
            end
            if (issue_fire) begin
                if (halt) begin
                    halted_q <= 1'b1;
                end else if (target_misaligned) begin
                    misalign_q <= 1'b1;
                end else begin
                    pc_q <= next_pc;
                end
            end
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign instr     = instr_q;
    assign halted    = halted_q;
    assign misalign  = misalign_q;

endmodule
